muldiv_unit: RTL and testbench

Iterative multi-cycle multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits directly upstream of the writeback result select. Its `result_o` is one candidate input to that select, and its `busy_o` stalls PC update and register-file write while an operation is in flight. Fixed latency, one operation at a time, start/done handshake with the control unit.

---
 rtl/muldiv_unit_pkg.sv | 36 +++
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 128 ++++++++++++
 tb/tb_muldiv_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M definitions: funct3 operation encoding and the muldiv FSM states.
package riscv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state_e;

  // rs1 is treated as signed for these ops
  function automatic logic op_signed_a(muldiv_op_e op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction

  // rs2 is treated as signed for these ops
  function automatic logic op_signed_b(muldiv_op_e op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction

  // funct3[2] separates the divide group from the multiply group
  function automatic logic op_is_div(muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Start/done handshake between the control unit and the muldiv unit.
interface muldiv_unit_if #(
  parameter int unsigned DataWidth = 32
);
  import riscv_pkg::*;

  logic                 start_i;
  muldiv_op_e           op_i;
  logic [DataWidth-1:0] op_a_i;
  logic [DataWidth-1:0] op_b_i;
  logic                 busy_o;
  logic                 done_o;
  logic [DataWidth-1:0] result_o;

  modport master (
    output start_i, op_i, op_a_i, op_b_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, op_a_i, op_b_i,
    output busy_o, done_o, result_o
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: fixed DataWidth+2 cycle latency, one op at a time.
// A single 2*DataWidth register holds {acc_hi, multiplier} while multiplying and
// {remainder, dividend/quotient} while dividing; sreg holds the multiplicand or divisor.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  muldiv_unit_if.slave  bus
);

  localparam int unsigned CntW = $clog2(DataWidth + 1);
  localparam int unsigned W2   = 2 * DataWidth;

  muldiv_state_e        state_q, state_d;
  logic [CntW-1:0]      cnt_q;
  muldiv_op_e           op_q;
  logic                 neg_a_q, neg_b_q, div_zero_q;
  logic [W2-1:0]        acc_q;
  logic [DataWidth-1:0] sreg_q;
  logic [DataWidth-1:0] result_q;
  logic                 done_q;

  logic                 sign_a, sign_b;
  logic [DataWidth-1:0] mag_a, mag_b;
  logic [DataWidth:0]   addend, add_sum, trial, diff;
  logic [W2-1:0]        mul_next, div_next, prod;
  logic [DataWidth-1:0] quot, rem, result_d;

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start_i) state_d = CALC;
      CALC: if (cnt_q == CntW'(DataWidth - 1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // operand signs and magnitudes as seen at the request
  always_comb begin
    sign_a = op_signed_a(bus.op_i) & bus.op_a_i[DataWidth-1];
    sign_b = op_signed_b(bus.op_i) & bus.op_b_i[DataWidth-1];
    mag_a  = sign_a ? -bus.op_a_i : bus.op_a_i;
    mag_b  = sign_b ? -bus.op_b_i : bus.op_b_i;
  end

  // one shift-add step and one restoring shift-subtract step
  always_comb begin
    addend   = acc_q[0] ? {1'b0, sreg_q} : '0;
    add_sum  = {1'b0, acc_q[W2-1:DataWidth]} + addend;
    mul_next = {add_sum, acc_q[DataWidth-1:1]};
    trial    = acc_q[W2-1:DataWidth-1];
    diff     = trial - {1'b0, sreg_q};
    div_next = diff[DataWidth] ? {acc_q[W2-2:0], 1'b0}
                               : {diff[DataWidth-1:0], acc_q[DataWidth-2:0], 1'b1};
  end

  // sign correction and divide-by-zero override of the final register contents;
  // with a zero divisor the remainder path already yields |a| re-signed, i.e. op_a
  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quot = (neg_a_q ^ neg_b_q) ? -acc_q[DataWidth-1:0] : acc_q[DataWidth-1:0];
    rem  = neg_a_q ? -acc_q[W2-1:DataWidth] : acc_q[W2-1:DataWidth];
    unique case (op_q)
      MUL:                 result_d = prod[DataWidth-1:0];
      MULH, MULHSU, MULHU: result_d = prod[W2-1:DataWidth];
      DIV, DIVU:           result_d = div_zero_q ? '1 : quot;
      default:             result_d = rem;
    endcase
  end

  // datapath, counter and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      op_q       <= MUL;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div_zero_q <= 1'b0;
      acc_q      <= '0;
      sreg_q     <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (bus.start_i) begin
          cnt_q      <= '0;
          op_q       <= bus.op_i;
          neg_a_q    <= sign_a;
          neg_b_q    <= sign_b;
          div_zero_q <= (bus.op_b_i == '0);
          if (op_is_div(bus.op_i)) begin
            acc_q  <= {{DataWidth{1'b0}}, mag_a};
            sreg_q <= mag_b;
          end else begin
            acc_q  <= {{DataWidth{1'b0}}, mag_b};
            sreg_q <= mag_a;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + CntW'(1);
          acc_q <= op_is_div(op_q) ? div_next : mul_next;
        end
        DONE: begin
          result_q <= result_d;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o   = (state_q != IDLE);
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed expected results.
module tb_muldiv_unit;
  import riscv_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  muldiv_unit_if #(.DataWidth(32)) bus ();

  muldiv_unit #(.DataWidth(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.op_i   = op;
    bus.op_a_i = a;
    bus.op_b_i = b;
  endtask

  // issue one op, then check latency, busy window, result and single-cycle done
  task automatic run_op(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int n;
    int busy_cnt;
    @(negedge clk);
    drive(op, a, b);
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    check({tag, "_busy0"}, 64'(bus.busy_o), 64'd1);
    n = 0;
    busy_cnt = 0;
    while (!bus.done_o && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus.busy_o) busy_cnt++;
    end
    check({tag, "_lat"}, 64'(n), 64'd33);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, "_res"}, 64'(bus.result_o), 64'(exp));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(bus.done_o), 64'd0);
    check({tag, "_hold"}, 64'(bus.result_o), 64'(exp));
  endtask

  initial begin
    int n;
    int done_seen;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.start_i = 1'b0;
    drive(MUL, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_result", 64'(bus.result_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
    run_op(MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, "mulh");
    run_op(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
    run_op(MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, "mulhsu_neg");
    run_op(MULHSU, 32'd2,        32'hFFFFFFFF, 32'h00000001, "mulhsu_unsb");
    run_op(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_neg");
    run_op(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_neg");
    run_op(DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, "div_negb");
    run_op(REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, "rem_negb");
    run_op(DIVU,   32'd100,      32'd7,        32'd14,       "divu");
    run_op(REMU,   32'd100,      32'd7,        32'd2,        "remu");
    run_op(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
    run_op(REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf");
    run_op(DIV,    32'd5,        32'd0,        32'hFFFFFFFF, "div_z");
    run_op(REMU,   32'd5,        32'd0,        32'd5,        "remu_z");
    run_op(DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, "div_z_neg");
    run_op(REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, "rem_z_neg");
    run_op(DIVU,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, "divu_z");

    // start pulsed mid-operation with other operands must be ignored
    @(negedge clk);
    drive(DIVU, 32'd100, 32'd7);
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    drive(MUL, 32'd3, 32'd3);
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    n = 6;
    while (!bus.done_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ign_lat", 64'(n), 64'd33);
    check("ign_res", 64'(bus.result_o), 64'd14);
    repeat (5) @(posedge clk);
    #1;
    check("ign_idle_busy", 64'(bus.busy_o), 64'd0);
    check("ign_idle_hold", 64'(bus.result_o), 64'd14);

    // reset in the middle of a divide discards it
    @(negedge clk);
    drive(DIV, 32'hFFFFFFF9, 32'd2);
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", 64'(bus.busy_o), 64'd0);
    check("mid_rst_done", 64'(bus.done_o), 64'd0);
    check("mid_rst_result", 64'(bus.result_o), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done_o) done_seen++;
    end
    check("mid_rst_no_done", 64'(done_seen), 64'd0);
    run_op(REMU, 32'd100, 32'd7, 32'd2, "post_rst");

    // start held high: second op accepted in the first IDLE cycle after DONE
    @(negedge clk);
    drive(MUL, 32'd6, 32'd7);
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!bus.done_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_first", 64'(bus.result_o), 64'd42);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    check("b2b_accept", 64'(bus.busy_o), 64'd1);
    n = 0;
    while (!bus.done_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_lat", 64'(n), 64'd33);
    check("b2b_second", 64'(bus.result_o), 64'd42);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
